// File: rtl/phase_corr_peak_finder.sv
// Peak search over one N x N correlation surface streamed column-major.
// Reports the |re|+|im| maximum as row/col indices and signed shifts.
module phase_corr_peak_finder #(
   parameter int N     = 128,
   parameter int LOG2N = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      s_axis_tdata,
   input  logic             s_axis_tvalid,
   output logic             s_axis_tready,
   input  logic             s_axis_tlast,
   output logic             peak_valid,
   input  logic             peak_ready,
   output logic [LOG2N-1:0] peak_row,
   output logic [LOG2N-1:0] peak_col,
   output logic [LOG2N-1:0] peak_dy,
   output logic [LOG2N-1:0] peak_dx,
   output logic [16:0]      peak_metric,
   output logic             tlast_err
);

   typedef enum logic {ACCUM, DONE} state_t;

   state_t           state_reg;
   logic [LOG2N-1:0] row_reg, col_reg;
   logic [LOG2N-1:0] best_row_reg, best_col_reg;
   logic [16:0]      best_reg;
   logic [LOG2N-1:0] peak_row_reg, peak_col_reg;
   logic [16:0]      peak_metric_reg;
   logic             tready_reg, peak_valid_reg, tlast_err_reg;

   logic [15:0]      abs_re, abs_im;
   logic [16:0]      metric;
   logic             accept, row_last, col_last, take;
   logic [16:0]      best_next;
   logic [LOG2N-1:0] best_row_next, best_col_next;

   // The first sample of a frame-set always loads, so a stale best never survives.
   always_comb begin
      abs_re        = s_axis_tdata[15] ? (~s_axis_tdata[15:0] + 16'd1) : s_axis_tdata[15:0];
      abs_im        = s_axis_tdata[31] ? (~s_axis_tdata[31:16] + 16'd1) : s_axis_tdata[31:16];
      metric        = {1'b0, abs_re} + {1'b0, abs_im};
      accept        = s_axis_tvalid && tready_reg;
      row_last      = (row_reg == LOG2N'(N - 1));
      col_last      = (col_reg == LOG2N'(N - 1));
      take          = ((row_reg == '0) && (col_reg == '0)) || (metric > best_reg);
      best_next     = take ? metric  : best_reg;
      best_row_next = take ? row_reg : best_row_reg;
      best_col_next = take ? col_reg : best_col_reg;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= ACCUM;
         row_reg         <= '0;
         col_reg         <= '0;
         best_reg        <= '0;
         best_row_reg    <= '0;
         best_col_reg    <= '0;
         peak_row_reg    <= '0;
         peak_col_reg    <= '0;
         peak_metric_reg <= '0;
         tready_reg      <= 1'b0;
         peak_valid_reg  <= 1'b0;
         tlast_err_reg   <= 1'b0;
      end else begin
         case (state_reg)
            ACCUM: begin
               tready_reg <= 1'b1;
               if (accept) begin
                  best_reg     <= best_next;
                  best_row_reg <= best_row_next;
                  best_col_reg <= best_col_next;
                  row_reg      <= row_reg + LOG2N'(1);
                  if (s_axis_tlast != row_last)
                     tlast_err_reg <= 1'b1;
                  if (row_last) begin
                     col_reg <= col_reg + LOG2N'(1);
                     if (col_last) begin
                        state_reg       <= DONE;
                        tready_reg      <= 1'b0;
                        peak_valid_reg  <= 1'b1;
                        peak_row_reg    <= best_row_next;
                        peak_col_reg    <= best_col_next;
                        peak_metric_reg <= best_next;
                     end
                  end
               end
            end
            DONE: begin
               if (peak_ready) begin
                  state_reg      <= ACCUM;
                  peak_valid_reg <= 1'b0;
                  tready_reg     <= 1'b1;
                  row_reg        <= '0;
                  col_reg        <= '0;
                  best_reg       <= '0;
                  best_row_reg   <= '0;
                  best_col_reg   <= '0;
               end
            end
            default: state_reg <= ACCUM;
         endcase
      end
   end

   // Displacements are the indices read as two's complement: upper half maps to negative shifts.
   assign peak_row      = peak_row_reg;
   assign peak_col      = peak_col_reg;
   assign peak_dy       = peak_row_reg;
   assign peak_dx       = peak_col_reg;
   assign peak_metric   = peak_metric_reg;
   assign peak_valid    = peak_valid_reg;
   assign s_axis_tready = tready_reg;
   assign tlast_err     = tlast_err_reg;

endmodule

// File: tb/tb_phase_corr_peak_finder.sv
// Scoreboard bench for phase_corr_peak_finder at N=64: a reference search runs
// as each frame is driven; the results are popped and compared when peak_valid rises.
module tb_phase_corr_peak_finder;
   localparam int N     = 64;
   localparam int LOG2N = 6;
   localparam int NS    = N * N;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [31:0]      s_axis_tdata = '0;
   logic             s_axis_tvalid = 1'b0;
   logic             s_axis_tready;
   logic             s_axis_tlast = 1'b0;
   logic             peak_valid;
   logic             peak_ready = 1'b0;
   logic [LOG2N-1:0] peak_row, peak_col, peak_dy, peak_dx;
   logic [16:0]      peak_metric;
   logic             tlast_err;

   phase_corr_peak_finder #(.N(N), .LOG2N(LOG2N)) dut (
      .clk(clk), .reset(reset),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
      .peak_valid(peak_valid), .peak_ready(peak_ready),
      .peak_row(peak_row), .peak_col(peak_col),
      .peak_dy(peak_dy), .peak_dx(peak_dx),
      .peak_metric(peak_metric), .tlast_err(tlast_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int row; int col; int metric; int dy; int dx; int err;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   n_res = 0;
   bit   exp_err = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, $signed(act), $signed(exp));
      end
   endtask

   function automatic int metric_of(input logic [31:0] d);
      int re, im;
      re = int'($signed(d[15:0]));
      im = int'($signed(d[31:16]));
      return (re < 0 ? -re : re) + (im < 0 ? -im : im);
   endfunction

   function automatic logic [31:0] gen(input int tc, input int r, input int c);
      logic [15:0] re, im;
      re = '0;
      im = '0;
      case (tc)
         1: if (c == 3 && r == 5) begin re = 16'd1000; im = -16'sd200; end
         2: if (c == N - 1 && r == N / 2) begin re = 16'h8000; im = 16'h8000; end
         3: begin
            re = 16'($urandom_range(0, 200) - 100);
            im = 16'($urandom_range(0, 200) - 100);
            if (c == 2 && r == 0) begin re = 16'd500; im = 16'd0; end
            if (c == 10 && r == 9) begin re = -16'sd250; im = 16'd250; end
         end
         4, 5: begin re = 16'($urandom); im = 16'($urandom); end
         6: begin
            re = 16'($urandom_range(0, 200) - 100);
            if (c == 1 && r == 36) re = 16'd30000;
         end
         7: begin
            re = 16'($urandom_range(0, 2000) - 1000);
            im = 16'($urandom_range(0, 2000) - 1000);
         end
         default: ;
      endcase
      return {im, re};
   endfunction

   // Entered and left just after a rising edge; one sample per cycle when tready holds.
   task automatic send(input logic [31:0] d, input logic l);
      int w;
      w = 0;
      s_axis_tdata  = d;
      s_axis_tlast  = l;
      s_axis_tvalid = 1'b1;
      @(negedge clk);
      while (!s_axis_tready && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (!s_axis_tready) check_val("tready_timeout", 32'(s_axis_tready), 32'd1);
      @(posedge clk);
      #1;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic drive_frame(input int tc, input int nsamp, input bit gaps);
      int mb, mr, mc, m, r, c;
      logic [31:0] d;
      logic l;
      exp_t e;
      mb = 0; mr = 0; mc = 0;
      for (int i = 0; i < nsamp; i++) begin
         r = i % N;
         c = i / N;
         d = gen(tc, r, c);
         l = (r == N - 1) ^ ((tc == 4 && c == 7 && r == 50) || (tc == 6 && c == 0 && r == 10));
         m = metric_of(d);
         if (i == 0 || m > mb) begin mb = m; mr = r; mc = c; end
         if (l != (r == N - 1)) exp_err = 1'b1;
         send(d, l);
         if (gaps && $urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
      if (nsamp == NS) begin
         e.row = mr; e.col = mc; e.metric = mb;
         e.dy = (mr < N / 2) ? mr : mr - N;
         e.dx = (mc < N / 2) ? mc : mc - N;
         e.err = int'(exp_err);
         sb.push_back(e);
      end
   endtask

   task automatic take_result(input int hold, input bit stuff);
      exp_t e;
      @(negedge clk);
      check_val("peak_valid_latency", 32'(peak_valid), 32'd1);
      check_val("tready_in_done", 32'(s_axis_tready), 32'd0);
      if (sb.size() == 0) begin
         check_val("scoreboard_empty", 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         n_res++;
         $display("result %0d: row=%0d col=%0d metric=%0d dy=%0d dx=%0d err=%0d (exp row=%0d col=%0d metric=%0d)",
                  n_res, peak_row, peak_col, peak_metric, $signed(peak_dy), $signed(peak_dx),
                  tlast_err, e.row, e.col, e.metric);
         check_val("peak_row", 32'(peak_row), e.row);
         check_val("peak_col", 32'(peak_col), e.col);
         check_val("peak_metric", 32'(peak_metric), e.metric);
         check_val("peak_dy", $signed(peak_dy), e.dy);
         check_val("peak_dx", $signed(peak_dx), e.dx);
         check_val("tlast_err", 32'(tlast_err), e.err);
         if (stuff) begin
            s_axis_tdata  = 32'd7000;
            s_axis_tvalid = 1'b1;
         end
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_val("hold_valid", 32'(peak_valid), 32'd1);
            check_val("hold_tready", 32'(s_axis_tready), 32'd0);
            check_val("hold_metric", 32'(peak_metric), e.metric);
            check_val("hold_row", 32'(peak_row), e.row);
            check_val("hold_col", 32'(peak_col), e.col);
         end
      end
      peak_ready = 1'b1;
      @(posedge clk);
      #1;
      peak_ready    = 1'b0;
      s_axis_tvalid = 1'b0;
      @(negedge clk);
      check_val("post_handshake_valid", 32'(peak_valid), 32'd0);
      check_val("post_handshake_tready", 32'(s_axis_tready), 32'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_val("reset_tready", 32'(s_axis_tready), 32'd0);
      check_val("reset_valid", 32'(peak_valid), 32'd0);
      check_val("reset_row", 32'(peak_row), 32'd0);
      check_val("reset_col", 32'(peak_col), 32'd0);
      check_val("reset_metric", 32'(peak_metric), 32'd0);
      check_val("reset_err", 32'(tlast_err), 32'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check_val("tready_after_reset", 32'(s_axis_tready), 32'd1);

      drive_frame(0, NS, 1'b0); take_result(0, 1'b0);
      drive_frame(1, NS, 1'b0); take_result(0, 1'b0);
      drive_frame(2, NS, 1'b0); take_result(3, 1'b0);
      drive_frame(3, NS, 1'b1); take_result(20, 1'b1);
      drive_frame(4, NS, 1'b1); take_result(2, 1'b0);
      drive_frame(5, NS, 1'b0); take_result(0, 1'b0);

      // Partial frame holding a large stale peak and a framing error, then reset.
      drive_frame(6, 3000, 1'b0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_val("midreset_tready", 32'(s_axis_tready), 32'd0);
      check_val("midreset_valid", 32'(peak_valid), 32'd0);
      check_val("midreset_err", 32'(tlast_err), 32'd0);
      check_val("midreset_metric", 32'(peak_metric), 32'd0);
      reset   = 1'b0;
      exp_err = 1'b0;
      @(posedge clk);
      #1;
      check_val("midreset_tready_up", 32'(s_axis_tready), 32'd1);
      drive_frame(7, NS, 1'b1); take_result(0, 1'b0);

      check_val("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
